// File: rtl/ca_corr_pkg.sv
// Shared definitions for the C/A early/prompt/late correlator.
// The optional saturating accumulators are enabled by defining CA_CORR_SATURATE_EN;
// the package itself is identical in both builds.
package ca_corr_pkg;

    // Chip_en pulses in one C/A code epoch.
    localparam int CHIPS_PER_EPOCH = 1023;

    // Default accumulator / output width.
    localparam int ACC_W_DEFAULT = 16;

    // Signed accumulator value at the default width.
    typedef logic signed [ACC_W_DEFAULT-1:0] acc_t;

    // ALIGN discards the partial epoch after reset; RUN integrates and dumps.
    typedef enum logic {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage : ca_corr_pkg

// File: rtl/corr_acc.sv
// Single signed up/down integrate-and-dump accumulator.
// Each sample_en moves the total by +1 on a match and -1 otherwise.
// sum_o shows the total including the current cycle's sample, so the parent
// can dump a boundary sample together with the rest of its epoch.
// Build option CA_CORR_SATURATE_EN: clamp at the signed limits instead of wrapping.
module corr_acc
    import ca_corr_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_en_i,
    input  logic                    match_i,
    input  logic                    dump_i,
    input  logic                    clear_i,
    output logic signed [ACC_W-1:0] sum_o
);

    localparam logic signed [ACC_W-1:0] ACC_ONE = {{(ACC_W-1){1'b0}}, 1'b1};

`ifdef CA_CORR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // Running total plus this cycle's +1/-1 contribution, if a sample arrives.
    always_comb begin
        sum_o = acc_q;
        if (sample_en_i) begin
`ifdef CA_CORR_SATURATE_EN
            if (match_i) begin
                if (acc_q != ACC_MAX) begin
                    sum_o = acc_q + ACC_ONE;
                end
            end else begin
                if (acc_q != ACC_MIN) begin
                    sum_o = acc_q - ACC_ONE;
                end
            end
`else
            sum_o = match_i ? (acc_q + ACC_ONE) : (acc_q - ACC_ONE);
`endif
        end
    end

    // A dump or a clear starts the next epoch from zero; otherwise keep integrating.
    always_comb begin
        acc_d = sum_o;
        if (clear_i || dump_i) begin
            acc_d = '0;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : corr_acc

// File: rtl/ca_correlator.sv
// 1-bit early/prompt/late integrate-and-dump correlator for a C/A code tracking loop.
// The prompt chip stream runs through a three-tap sample delay line; every sample
// is correlated against each tap, and at every 1023-chip epoch boundary the three
// totals are dumped into a holding register guarded by a valid/ack handshake.
// Build option CA_CORR_SATURATE_EN: saturating accumulators (default is wrapping).
module ca_correlator #(
    parameter int ACC_W           = ca_corr_pkg::ACC_W_DEFAULT,
    parameter int CHIPS_PER_EPOCH = ca_corr_pkg::CHIPS_PER_EPOCH,
    parameter int CNT_W           = 10
) (
    input  logic                    clk,
    input  logic                    sync,
    input  logic                    chip_en,
    input  logic                    ca_chip,
    input  logic                    sample_en,
    input  logic                    sample,
    input  logic                    dump_ack,
    output logic signed [ACC_W-1:0] early,
    output logic signed [ACC_W-1:0] prompt,
    output logic signed [ACC_W-1:0] late,
    output logic                    dump_valid,
    output logic                    overrun,
    output logic [CNT_W-1:0]        chip_cnt
);

    import ca_corr_pkg::*;

    localparam logic [CNT_W-1:0] LAST_CHIP = CNT_W'(CHIPS_PER_EPOCH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state_q;

    logic [CNT_W-1:0] chip_cnt_q;
    logic [CNT_W-1:0] chip_cnt_d;

    logic e_tap_q;
    logic p_tap_q;
    logic l_tap_q;

    logic signed [ACC_W-1:0] early_q;
    logic signed [ACC_W-1:0] prompt_q;
    logic signed [ACC_W-1:0] late_q;
    logic                    dump_valid_q;
    logic                    overrun_q;

    logic signed [ACC_W-1:0] early_sum;
    logic signed [ACC_W-1:0] prompt_sum;
    logic signed [ACC_W-1:0] late_sum;

    logic epoch_end;
    logic acc_clear;
    logic acc_dump;
    logic match_e;
    logic match_p;
    logic match_l;

    assign epoch_end = chip_en && (chip_cnt_q == LAST_CHIP);
    assign acc_clear = (state_q == ALIGN);
    assign acc_dump  = (state_q == RUN) && epoch_end;

    assign match_e = ~(sample ^ e_tap_q);
    assign match_p = ~(sample ^ p_tap_q);
    assign match_l = ~(sample ^ l_tap_q);

    // Chip index within the epoch: advance per chip, wrap to zero on the last chip.
    always_comb begin
        chip_cnt_d = chip_cnt_q;
        if (epoch_end) begin
            chip_cnt_d = '0;
        end else if (chip_en) begin
            chip_cnt_d = chip_cnt_q + CNT_ONE;
        end
    end

    // One-sample-spaced early/prompt/late taps of the local code.
    always_ff @(posedge clk or posedge sync) begin
        if (sync) begin
            e_tap_q <= 1'b0;
            p_tap_q <= 1'b0;
            l_tap_q <= 1'b0;
        end else if (sample_en) begin
            e_tap_q <= ca_chip;
            p_tap_q <= e_tap_q;
            l_tap_q <= p_tap_q;
        end
    end

    corr_acc #(
        .ACC_W (ACC_W)
    ) u_acc_early (
        .clk         (clk),
        .rst         (sync),
        .sample_en_i (sample_en),
        .match_i     (match_e),
        .dump_i      (acc_dump),
        .clear_i     (acc_clear),
        .sum_o       (early_sum)
    );

    corr_acc #(
        .ACC_W (ACC_W)
    ) u_acc_prompt (
        .clk         (clk),
        .rst         (sync),
        .sample_en_i (sample_en),
        .match_i     (match_p),
        .dump_i      (acc_dump),
        .clear_i     (acc_clear),
        .sum_o       (prompt_sum)
    );

    corr_acc #(
        .ACC_W (ACC_W)
    ) u_acc_late (
        .clk         (clk),
        .rst         (sync),
        .sample_en_i (sample_en),
        .match_i     (match_l),
        .dump_i      (acc_dump),
        .clear_i     (acc_clear),
        .sum_o       (late_sum)
    );

    // Epoch FSM with the chip counter, dump holding register and handshake flags.
    always_ff @(posedge clk or posedge sync) begin
        if (sync) begin
            state_q      <= ALIGN;
            chip_cnt_q   <= '0;
            early_q      <= '0;
            prompt_q     <= '0;
            late_q       <= '0;
            dump_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            chip_cnt_q <= chip_cnt_d;
            case (state_q)
                ALIGN: begin
                    if (epoch_end) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (epoch_end) begin
                        early_q      <= early_sum;
                        prompt_q     <= prompt_sum;
                        late_q       <= late_sum;
                        dump_valid_q <= 1'b1;
                        if (dump_valid_q && !dump_ack) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (dump_valid_q && dump_ack) begin
                        dump_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ALIGN;
                end
            endcase
        end
    end

    assign early      = early_q;
    assign prompt     = prompt_q;
    assign late       = late_q;
    assign dump_valid = dump_valid_q;
    assign overrun    = overrun_q;
    assign chip_cnt   = chip_cnt_q;

endmodule : ca_correlator

// File: tb/tb_ca_correlator.sv
// Directed bench for ca_correlator: a 16-bit instance and an 8-bit instance share
// one stimulus stream. The local code toggles every chip, with four samples per chip,
// so each 4092-sample epoch contains exactly 1023 chip transitions; an early or late
// tap therefore disagrees with prompt on 1023 samples, giving +/-2046.
`timescale 1ns/1ps
module tb_ca_correlator;

    logic clk = 1'b0;
    logic sync;
    logic chip_en;
    logic ca_chip;
    logic sample_en;
    logic sample;
    logic dump_ack;

    logic signed [15:0] early;
    logic signed [15:0] prompt;
    logic signed [15:0] late;
    logic               dump_valid;
    logic               overrun;
    logic [9:0]         chip_cnt;

    logic signed [7:0]  early8;
    logic signed [7:0]  prompt8;
    logic signed [7:0]  late8;
    logic               dump_valid8;
    logic               overrun8;
    logic [9:0]         chip_cnt8;

    int total = 0;
    int bad   = 0;

    // Reference copy of the code delay line and chip position.
    logic tbE;
    logic tbP;
    logic tbL;
    int   phase;
    int   chipIdx;
    logic invertMode;

`ifdef CA_CORR_SATURATE_EN
    localparam int PROMPT8_POS = 127;
    localparam int PROMPT8_NEG = -128;
`else
    localparam int PROMPT8_POS = -4;
    localparam int PROMPT8_NEG = 4;
`endif

    always #5 clk = ~clk;

    ca_correlator dut (
        .clk        (clk),
        .sync       (sync),
        .chip_en    (chip_en),
        .ca_chip    (ca_chip),
        .sample_en  (sample_en),
        .sample     (sample),
        .dump_ack   (dump_ack),
        .early      (early),
        .prompt     (prompt),
        .late       (late),
        .dump_valid (dump_valid),
        .overrun    (overrun),
        .chip_cnt   (chip_cnt)
    );

    ca_correlator #(
        .ACC_W (8)
    ) dut8 (
        .clk        (clk),
        .sync       (sync),
        .chip_en    (chip_en),
        .ca_chip    (ca_chip),
        .sample_en  (sample_en),
        .sample     (sample),
        .dump_ack   (dump_ack),
        .early      (early8),
        .prompt     (prompt8),
        .late       (late8),
        .dump_valid (dump_valid8),
        .overrun    (overrun8),
        .chip_cnt   (chip_cnt8)
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Drive chip strobe and sample from the reference delay line.
    task automatic applyStimulus();
        chip_en = (phase == 3);
        sample  = invertMode ? ~tbP : tbP;
    endtask

    task automatic stepClk();
        logic chipNow;
        logic chipStrobe;
        @(posedge clk);
        chipNow    = ca_chip;
        chipStrobe = chip_en;
        if (sample_en) begin
            tbL = tbP;
            tbP = tbE;
            tbE = chipNow;
        end
        if (chipStrobe) begin
            chipIdx = (chipIdx == 1022) ? 0 : chipIdx + 1;
        end
        phase = (phase + 1) % 4;
        #1;
        if (chipStrobe) begin
            ca_chip = ~chipNow;
        end
        applyStimulus();
    endtask

    // Advance until the currently driven cycle is an epoch boundary.
    task automatic runToBoundary(input string tag);
        int n = 0;
        while (!(chip_en && chipIdx == 1022) && n < 5000) begin
            stepClk();
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $error("[TB] FAIL %s: observed=no boundary expected=boundary within 5000 clk", tag);
        end
    endtask

    task automatic runToChip(input int target);
        int n = 0;
        while (chipIdx != target && n < 5000) begin
            stepClk();
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $error("[TB] FAIL run_to_chip: observed=%0d expected=%0d", chipIdx, target);
        end
    endtask

    task automatic resetModel();
        tbE        = 1'b0;
        tbP        = 1'b0;
        tbL        = 1'b0;
        phase      = 0;
        chipIdx    = 0;
        ca_chip    = 1'b0;
        invertMode = 1'b0;
        applyStimulus();
    endtask

    initial begin
        sync      = 1'b1;
        sample_en = 1'b0;
        dump_ack  = 1'b0;
        resetModel();
        #12;
        checkOutput("rst_early", early, 0);
        checkOutput("rst_prompt", prompt, 0);
        checkOutput("rst_late", late, 0);
        checkOutput("rst_valid", dump_valid, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_chip_cnt", chip_cnt, 0);

        @(negedge clk);
        sync      = 1'b0;
        sample_en = 1'b1;
        applyStimulus();
        repeat (4) stepClk();
        checkOutput("chip_cnt_first", chip_cnt, 1);

        // First boundary only leaves ALIGN; nothing is dumped.
        runToBoundary("align_boundary");
        stepClk();
        checkOutput("align_no_dump", dump_valid, 0);
        checkOutput("align_cnt_wrap", chip_cnt, 0);
        checkOutput("align_prompt", prompt, 0);

        // First full epoch, aligned signal.
        runToBoundary("epoch_aligned");
        checkOutput("aligned_valid_pre", dump_valid, 0);
        stepClk();
        checkOutput("aligned_valid", dump_valid, 1);
        checkOutput("aligned_prompt", prompt, 4092);
        checkOutput("aligned_early", early, 2046);
        checkOutput("aligned_late", late, 2046);
        checkOutput("aligned_prompt8", prompt8, PROMPT8_POS);
        checkOutput("aligned_overrun", overrun, 0);

        // Inverted epoch; ack the previous dump on its first cycle.
        invertMode = 1'b1;
        applyStimulus();
        dump_ack = 1'b1;
        stepClk();
        dump_ack = 1'b0;
        checkOutput("ack_clears_valid", dump_valid, 0);
        checkOutput("hold_prompt", prompt, 4092);
        runToBoundary("epoch_inverted");
        stepClk();
        checkOutput("inv_prompt", prompt, -4092);
        checkOutput("inv_early", early, -2046);
        checkOutput("inv_late", late, -2046);
        checkOutput("inv_prompt8", prompt8, PROMPT8_NEG);
        checkOutput("inv_valid", dump_valid, 1);
        checkOutput("inv_overrun", overrun, 0);

        // Aligned epoch whose boundary collides with an ack.
        invertMode = 1'b0;
        applyStimulus();
        runToBoundary("epoch_collision");
        dump_ack = 1'b1;
        stepClk();
        dump_ack = 1'b0;
        checkOutput("coll_valid", dump_valid, 1);
        checkOutput("coll_overrun", overrun, 0);
        checkOutput("coll_prompt", prompt, 4092);
        checkOutput("coll_early", early, 2046);

        // Inverted epoch with no ack: overrun, new data overwrites.
        invertMode = 1'b1;
        applyStimulus();
        runToBoundary("epoch_overrun");
        stepClk();
        checkOutput("ovr_overrun", overrun, 1);
        checkOutput("ovr_valid", dump_valid, 1);
        checkOutput("ovr_prompt", prompt, -4092);
        checkOutput("ovr_late", late, -2046);
        dump_ack = 1'b1;
        stepClk();
        dump_ack = 1'b0;
        checkOutput("ovr_ack_valid", dump_valid, 0);
        checkOutput("ovr_sticky", overrun, 1);
        checkOutput("ovr_hold_prompt", prompt, -4092);
        dump_ack = 1'b1;
        stepClk();
        dump_ack = 1'b0;
        checkOutput("idle_ack_ignored", dump_valid, 0);

        // Asynchronous reset in the middle of an epoch.
        invertMode = 1'b0;
        applyStimulus();
        runToChip(500);
        checkOutput("mid_chip_cnt", chip_cnt, 500);
        #2;
        sync = 1'b1;
        #1;
        checkOutput("mid_rst_prompt", prompt, 0);
        checkOutput("mid_rst_early", early, 0);
        checkOutput("mid_rst_late", late, 0);
        checkOutput("mid_rst_valid", dump_valid, 0);
        checkOutput("mid_rst_overrun", overrun, 0);
        checkOutput("mid_rst_chip_cnt", chip_cnt, 0);
        resetModel();
        @(negedge clk);
        sync = 1'b0;
        repeat (4) stepClk();
        checkOutput("post_rst_cnt", chip_cnt, 1);
        runToBoundary("post_rst_align");
        stepClk();
        checkOutput("post_rst_no_dump", dump_valid, 0);
        runToBoundary("post_rst_epoch");
        checkOutput("post_rst_valid_pre", dump_valid, 0);
        stepClk();
        checkOutput("post_rst_valid", dump_valid, 1);
        checkOutput("post_rst_prompt", prompt, 4092);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ca_correlator

// File: doc/ca_correlator.md
Name: ca_correlator

Overview:
- Downstream consumer of the C/A code generator and the XOR signal mixer.
- Performs 1-bit early/prompt/late integrate-and-dump correlation of the mixed baseband sample stream against the locally generated C/A chip stream.
- Counts chips to find the 1023-chip code epoch, dumps the three accumulators into a holding register, and flags the result to the tracking logic with a valid/ack handshake.

Parameters:
- ACC_W, 16, signed accumulator and output width (two's complement).
- CHIPS_PER_EPOCH, 1023, chip_en pulses per integration period.
- CNT_W, 10, chip counter width; must satisfy 2^CNT_W >= CHIPS_PER_EPOCH.

Ports:
- clk  in  1  system clock.
- sync  in  1  asynchronous active-high reset, same net that reloads the code generator shift registers.
- chip_en  in  1  one-cycle pulse per code chip (same strobe that clocks the G1/G2 registers).
- ca_chip  in  1  current prompt C/A chip (G1 output XOR G2 tap).
- sample_en  in  1  one-cycle pulse per input sample.
- sample  in  1  mixed 1-bit sample from the XOR mixer.
- dump_ack  in  1  consumer has read early/prompt/late.
- early  out  ACC_W  dumped early correlation.
- prompt  out  ACC_W  dumped prompt correlation.
- late  out  ACC_W  dumped late correlation.
- dump_valid  out  1  holding register contains unread data.
- overrun  out  1  sticky: a dump occurred while dump_valid was still 1.
- chip_cnt  out  CNT_W  current chip index within the epoch.

Behaviour:
- Reset (sync=1, asynchronous): all accumulators, early/prompt/late, chip_cnt, delay line, dump_valid and overrun are 0; state is ALIGN.
- Delay line: 3-bit shift register clocked by sample_en. It shifts ca_chip in at tap e; tap e moves to p, and tap p moves to l. Early/prompt/late spacing is therefore one sample.
- Accumulation: on each sample_en, every accumulator adds +1 if sample XNOR its tap is 1, and -1 otherwise.
- Chip counter:
  - Increments on chip_en.
  - Epoch boundary is a chip_en with chip_cnt == CHIPS_PER_EPOCH-1; chip_cnt wraps to 0.
  - chip_cnt never exceeds CHIPS_PER_EPOCH-1.
- State ALIGN:
  - Accumulators are cleared every cycle.
  - The first epoch boundary moves the state to RUN with no dump, which discards the partial epoch after reset.
- State RUN, at each epoch boundary:
  - Accumulator values, including this cycle's sample contribution if sample_en is also high, are copied to early/prompt/late.
  - Accumulators clear to 0.
  - dump_valid is set to 1 on the next cycle edge, so latency is 1 clk from the boundary.
- Simultaneous sample_en and boundary: the sample belongs to the ending epoch. The next epoch starts from 0.
- Handshake and overrun:
  - dump_ack with dump_valid=1 clears dump_valid.
  - A boundary in the same cycle as dump_ack wins: dump_valid stays 1, new data is loaded, overrun is not set.
  - A boundary with dump_valid=1 and no ack overwrites the outputs with new data and sets overrun=1. overrun clears only on sync.
  - dump_ack while dump_valid=0 is ignored.
- Outputs hold their value between dumps.

Optional Feature:
- Macro: CA_CORR_SATURATE_EN.
- Defined: accumulators clamp at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)).
- Undefined: accumulators wrap modulo 2^ACC_W, with no extra logic.

Decomposition:
- Shared package ca_corr_pkg holds:
  - CHIPS_PER_EPOCH = 1023;
  - default ACC_W;
  - acc_t typedef (signed [ACC_W-1:0]);
  - state enum {ALIGN, RUN}.
- Sub-module corr_acc: a single signed up/down accumulator with sample_en, match, dump and clear inputs and the optional saturation. It is instantiated three times.

Test Plan:
- Aligned signal: sample_en every clk, chip_en every 4 clk, sample = delayed prompt tap. Required: after the first full epoch, prompt = +4092 and dump_valid = 1 exactly 1 clk after the boundary; early and late < 4092.
- Inverted signal: sample = NOT prompt tap. Required: prompt = -4092.
- Overrun: no dump_ack across two consecutive RUN epochs. Required: overrun = 1 and outputs hold the second epoch's values. Then assert dump_ack alone: dump_valid = 0 and overrun stays 1.
- Ack/boundary collision: dump_ack asserted on the boundary cycle. Required: dump_valid stays 1, overrun = 0, new values are loaded.
- Width with ACC_W = 8, aligned, 4092 samples:
  - with CA_CORR_SATURATE_EN, prompt = 127;
  - without it, prompt = -4 (4092 mod 256 = 252).
- Reset mid-epoch at chip 500: all outputs 0 immediately (asynchronously) and state ALIGN. The first dump_valid appears only at the second boundary after reset release, and chip_cnt restarts at 0.
